ripple_count_sampler: RTL
=========================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the ripple counter built from the team's D flip-flop stages.
- The counter's output is asynchronous to the system clock and its bits settle at different times. This block synchronizes the raw count and captures a value only once it has been stable for several cycles.
- It presents the captured count, the delta since the previous capture, and a wrap flag on a valid/ready interface to the system-clock domain.

Parameters:
- WIDTH, 4, ripple counter width in bits.
- STABLE_CNT, 2, consecutive equal synchronized samples required before capture (legal range 1..15).
- TIMEOUT_CYC, 16, maximum cycles spent in SETTLE before a forced capture (must be greater than STABLE_CNT).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cnt_raw  input  WIDTH  raw ripple counter q bits; asynchronous to clk.
- sample_req  input  1  request one capture; sampled only in IDLE.
- out_ready  input  1  consumer accepts the result.
- out_valid  output  1  result available.
- out_count  output  WIDTH  captured count.
- out_delta  output  WIDTH  out_count minus the previous capture, mod 2^WIDTH.
- out_wrap  output  1  counter wrapped: out_count is less than the previous capture.
- timeout_err  output  1  this result was force-captured at timeout.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - all outputs to 0;
  - both synchronizer stages, prev, last_count, match_cnt and tmo_cnt to 0;
  - the state to IDLE.
- Synchronizer:
  - each cnt_raw bit passes through a 2-flop synchronizer to produce sync2;
  - a raw change is visible in sync2 two edges later;
  - no logic uses cnt_raw directly.
- IDLE:
  - if sample_req=1 at an edge, go to SETTLE; prev <= sync2; match_cnt <= 0; tmo_cnt <= 0;
  - otherwise hold.
- SETTLE, evaluated on each edge:
  - tmo_cnt increments.
  - If sync2 == prev, match_cnt increments.
  - If sync2 != prev, match_cnt <= 0 and prev <= sync2.
  - When an equal compare brings match_cnt to STABLE_CNT, capture prev and set timeout_err=0.
  - Otherwise, when tmo_cnt reaches TIMEOUT_CYC, capture sync2 and set timeout_err=1.
  - If both conditions occur on the same edge, the stable capture wins.
- Capture, on the same edge as the condition above:
  - out_count <= C;
  - out_delta <= C - last_count, truncated to WIDTH;
  - out_wrap <= (C < last_count);
  - last_count <= C;
  - out_valid <= 1; go to HOLD.
- Latency with a constant input: sample_req taken at edge k gives out_valid high after edge k+STABLE_CNT.
- HOLD:
  - all out_* outputs and timeout_err are held stable;
  - when out_valid && out_ready at an edge, out_valid <= 0 and go to IDLE;
  - sample_req is ignored in the same cycle; a new request is taken from IDLE at the next edge at the earliest.
- sample_req while busy=1 is ignored and not queued.
- out_ready while out_valid=0 is ignored.
- last_count persists across captures and is cleared only by reset. The first capture after reset therefore reports a delta of C - 0.
- Reset mid-SETTLE or mid-HOLD: immediate return to IDLE with all outputs 0; any pending result is lost.

Decomposition:
- Package ripple_sampler_pkg holds:
  - the state enum {IDLE, SETTLE, HOLD}, encoded 2'b00/01/10;
  - widths of the match and timeout counters, derived as $clog2 of the parameters plus 1.
- One sub-module, bit_sync: a single-bit 2-flop synchronizer with clk and rst_n, instantiated WIDTH times with a generate loop.

Test Plan:
1. Reset then steady input: rst_n low for 3 cycles, cnt_raw=4'h5 held, sample_req pulsed at edge k, out_ready=1 -> out_valid high after edge k+2; out_count=5, out_delta=5, out_wrap=0, timeout_err=0; busy falls the cycle after the handshake.
2. Wrap: capture 4'hE, then set cnt_raw=4'h3 and capture again -> out_count=3, out_delta=5, out_wrap=1.
3. Glitching input: cnt_raw toggles 4'h7/4'h8 every cycle for 30 cycles after sample_req -> capture exactly at tmo_cnt=16 with timeout_err=1 and out_count equal to that cycle's sync2. The next stable request gives timeout_err=0.
4. Back-pressure: out_ready=0 for 10 cycles after out_valid, with cnt_raw changed and sample_req pulsed meanwhile -> outputs frozen and the request ignored; on out_ready=1, one handshake, then IDLE.
5. Mid-settle change: cnt_raw changes 4'h2 to 4'h3 one cycle after sample_req -> match_cnt restarts when 3 appears at sync2; out_count=3 and timeout_err=0.
6. Asynchronous reset in HOLD: assert rst_n between clock edges -> out_valid, out_count and busy drop to 0 without waiting for an edge. The next capture of 4'h4 gives out_delta=4, because last_count was cleared.

Source files
------------

// File: rtl/ripple_sampler_pkg.sv
// ---------------------------------------------------------------------------
// ripple_sampler_pkg
//
// Shared types and helpers for the ripple counter sampler.
//   state_t   : sampler FSM states (IDLE / SETTLE / HOLD)
//   cnt_width : width of a counter that must be able to hold 0..limit
// ---------------------------------------------------------------------------
package ripple_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETTLE = 2'b01,
      HOLD   = 2'b10
   } state_t;

   localparam int DEF_STABLE_CNT  = 2;
   localparam int DEF_TIMEOUT_CYC = 16;

   // One extra bit over $clog2 so the terminal value itself is representable
   // (e.g. a limit of 16 needs 5 bits, not 4).
   function automatic int cnt_width(input int limit);
      return $clog2(limit) + 1;
   endfunction

   localparam int DEF_MATCH_W = cnt_width(DEF_STABLE_CNT);
   localparam int DEF_TMO_W   = cnt_width(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
//
// Single-bit two-flop synchronizer into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input bit
//   q     : synchronized bit, two rising edges behind d
// ---------------------------------------------------------------------------
module bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   // First stage may go metastable; second stage gives it a full cycle to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// ripple_count_sampler
//
// Synchronizes the raw ripple counter bits, waits until the synchronized
// value has been stable for STABLE_CNT consecutive compares (or forces a
// capture after TIMEOUT_CYC cycles), and presents the captured count, the
// delta since the previous capture and a wrap flag on a valid/ready port.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   cnt_raw     : raw ripple counter bits, asynchronous to clk
//   sample_req  : request one capture (only honoured in IDLE)
//   out_ready   : consumer accepts the presented result
//   out_valid   : result available
//   out_count   : captured count
//   out_delta   : out_count minus previous capture, mod 2^WIDTH
//   out_wrap    : out_count is below the previous capture
//   timeout_err : result was force-captured at timeout
//   busy        : state is not IDLE
// ---------------------------------------------------------------------------
module ripple_count_sampler #(
   parameter int WIDTH       = 4,
   parameter int STABLE_CNT  = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] cnt_raw,
   input  logic             sample_req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_count,
   output logic [WIDTH-1:0] out_delta,
   output logic             out_wrap,
   output logic             timeout_err,
   output logic             busy
);

   import ripple_sampler_pkg::*;

   localparam int MW = cnt_width(STABLE_CNT);
   localparam int TW = cnt_width(TIMEOUT_CYC);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] last_count;
   logic [MW-1:0]    match_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic [MW-1:0]    match_inc;
   logic [TW-1:0]    tmo_inc;
   logic             same;
   logic             stable_hit;
   logic             tmo_hit;
   logic             cap_en;
   logic             cap_tmo;
   logic [WIDTH-1:0] cap_val;

   // Every counter bit gets its own synchronizer; nothing else touches cnt_raw.
   for (genvar i = 0; i < WIDTH; i++) begin : g_sync
      bit_sync u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (cnt_raw[i]),
         .q     (sync2[i])
      );
   end

   // Stable capture is judged on the incremented match count so it fires on
   // the very compare that makes the run long enough.
   assign same       = (sync2 == prev);
   assign match_inc  = match_cnt + 1'b1;
   assign tmo_inc    = tmo_cnt + 1'b1;
   assign stable_hit = same && (match_inc == MW'(STABLE_CNT));
   assign tmo_hit    = (tmo_inc == TW'(TIMEOUT_CYC));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sample_req) next_state = SETTLE;
         SETTLE:  if (stable_hit || tmo_hit) next_state = HOLD;
         HOLD:    if (out_valid && out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output/control decode; a stable capture takes priority over a timeout
   // landing on the same edge.
   always_comb begin
      busy    = (state != IDLE);
      cap_en  = (state == SETTLE) && (stable_hit || tmo_hit);
      cap_tmo = !stable_hit;
      cap_val = stable_hit ? prev : sync2;
   end

   // Datapath: settle tracking, capture and result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev        <= '0;
         last_count  <= '0;
         match_cnt   <= '0;
         tmo_cnt     <= '0;
         out_valid   <= 1'b0;
         out_count   <= '0;
         out_delta   <= '0;
         out_wrap    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sample_req) begin
                  prev      <= sync2;
                  match_cnt <= '0;
                  tmo_cnt   <= '0;
               end
            end
            SETTLE: begin
               tmo_cnt <= tmo_inc;
               if (same) begin
                  match_cnt <= match_inc;
               end else begin
                  match_cnt <= '0;
                  prev      <= sync2;
               end
               if (cap_en) begin
                  out_count   <= cap_val;
                  out_delta   <= cap_val - last_count;
                  out_wrap    <= (cap_val < last_count);
                  timeout_err <= cap_tmo;
                  last_count  <= cap_val;
                  out_valid   <= 1'b1;
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
